mips32_multi_cycle_control: RTL and testbench
=============================================

Name: mips32_multi_cycle_control

Overview:
- Main control FSM for the multi-cycle MIPS32 datapath, the next step after the single-cycle core.
- Sequences fetch, decode, execute, memory and writeback over several clocks per instruction, sharing one ALU and one unified memory.
- Drives every datapath mux and enable, and keeps a retired-instruction counter that the testbench prints alongside result.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; forces FETCH and clears the counter.
- opcode  in  6  IR[31:26], valid from DECODE onward.
- funct  in  6  IR[5:0], valid from DECODE onward.
- zero  in  1  ALU zero flag, combinational, sampled in BRANCH.
- pc_en  out  1  PC register load enable.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  instruction register load.
- reg_dst  out  1  write register select: 0 = rt, 1 = rd.
- mem_to_reg  out  1  writeback data select: 0 = ALUOut, 1 = MDR.
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = A register.
- alu_src_b  out  2  ALU B select: 00 = B, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm<<2.
- alu_op  out  3  ALU operation class: 000 add, 001 sub, 010 R-type (decode funct), 011 and, 100 or, 101 slt.
- pc_source  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- state  out  4  current state encoding, for debug.
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction.
- illegal_op  out  1  one-cycle pulse when an unsupported opcode is decoded.
- retired  out  CNT_W  count of completed instructions.

Behaviour:
- Reset is asynchronous and active-high. While reset is asserted:
  - state = FETCH (0) and retired = 0.
  - Outputs take the FETCH decode, except pc_en, ir_write, mem_read and instr_done, which are forced to 0.
- All outputs are Moore decodes of state, except pc_en in BRANCH, which depends on zero. Every output not listed for a state is 0.
- States, with the outputs asserted in each:
  - 0 FETCH: mem_read, ir_write, alu_src_b=01, alu_op=add, pc_source=00, pc_en. Next: DECODE.
  - 1 DECODE: alu_src_b=11, alu_op=add (precomputes the branch target).
    - 100011/101011 → MEMADR; 000000 → RTYPE; 000100/000101 → BRANCH; 000010 → JUMP; 001000/001100/001101/001010 → IEXEC.
    - Any other opcode → FETCH, with illegal_op and instr_done both pulsed in DECODE.
  - 2 MEMADR: alu_src_a=1, alu_src_b=10, alu_op=add. lw → MEMRD; sw → MEMWR.
  - 3 MEMRD: iord=1, mem_read. Next: MEMWB.
  - 4 MEMWB: reg_write, mem_to_reg=1, reg_dst=0, instr_done. Next: FETCH.
  - 5 MEMWR: iord=1, mem_write, instr_done. Next: FETCH.
  - 6 RTYPE: alu_src_a=1, alu_src_b=00, alu_op=010. Next: RWB.
  - 7 RWB: reg_write, reg_dst=1, instr_done. Next: FETCH.
  - 8 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=sub, pc_source=01, instr_done.
    - pc_en = zero for beq, ~zero for bne.
    - Next: FETCH.
  - 9 JUMP: pc_source=10, pc_en, instr_done. Next: FETCH.
  - 10 IEXEC: alu_src_a=1, alu_src_b=10. alu_op = add (addi), and (andi), or (ori), slt (slti). Next: IWB.
  - 11 IWB: reg_write, reg_dst=0, mem_to_reg=0, instr_done. Next: FETCH.
  - Codes 12–15 are unreachable; if entered, go to FETCH with all outputs 0.
- Opcode is re-decoded combinationally in MEMADR and IEXEC. The IR is stable there because ir_write is asserted only in FETCH.
- retired increments by 1 on each clock edge where instr_done = 1, including illegal decodes. It wraps modulo 2^CNT_W with no saturation.
- Cycle counts per instruction: lw 5; sw, R-type and immediate ops 4; beq, bne and j 3; illegal 2.
- Reset asserted mid-instruction aborts immediately: no write strobe is asserted after reset rises, and the next fetch begins on the first edge after reset falls.

Decomposition:
- Shared package mips32_pkg holds:
  - State localparams (FETCH..IWB).
  - Opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI.
  - ALU op codes and alu_src_b encodings.
- One sub-module is natural: mips32_ctrl_decode, a pure combinational decode of (state, opcode, zero) to all control outputs. The top module holds the state register, next-state logic and retired counter.

Test Plan:
- Reset, then lw (opcode 100011) held → states 0,1,2,3,4,0; reg_write and mem_to_reg both 1 only in state 4; retired = 1 after 5 edges.
- sw (101011) → mem_write = 1 and iord = 1 exactly in state 5; reg_write never asserted; 4 cycles.
- beq with zero=1, then beq with zero=0, then bne with zero=0 → pc_en in BRANCH = 1, 0, 1 respectively; each instruction takes 3 cycles.
- ori (001101) → IEXEC drives alu_op = 100 and alu_src_b = 10; IWB drives reg_write = 1 and reg_dst = 0.
- Opcode 111111 → illegal_op and instr_done pulse in DECODE, return to FETCH, retired increments; j (000010) then drives pc_source = 10 and pc_en = 1.
- Reset pulsed during MEMRD → state reads 0 asynchronously with no mem_write or reg_write; retired = 0; normal fetch resumes after reset deasserts.

Source files
------------

// File: rtl/mips32_pkg.sv
// Shared definitions for the multi-cycle MIPS32 control path: state codes,
// opcodes, ALU/mux encodings and the bundled control-word type.
package mips32_pkg;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        RTYPE  = 4'd6,
        RWB    = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9,
        IEXEC  = 4'd10,
        IWB    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_RTYPE = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_OR    = 3'b100;
    localparam logic [2:0] ALU_SLT   = 3'b101;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_en;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
        logic       illegal_op;
    } ctrl_t;

    function automatic logic is_legal_op(input logic [5:0] op);
        return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J,
                          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI};
    endfunction

endpackage

// File: rtl/mips32_multi_cycle_control_if.sv
// Control-path bundle between the main FSM (master) and the datapath (slave).
interface mips32_multi_cycle_control_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             zero;
    logic             pc_en;
    logic             iord;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             reg_write;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [2:0]       alu_op;
    logic [1:0]       pc_source;
    logic [3:0]       state;
    logic             instr_done;
    logic             illegal_op;
    logic [CNT_W-1:0] retired;

    modport master (
        input  opcode, funct, zero,
        output pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, alu_op, pc_source, state,
               instr_done, illegal_op, retired
    );

    modport slave (
        output opcode, funct, zero,
        input  pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, alu_op, pc_source, state,
               instr_done, illegal_op, retired
    );
endinterface

// File: rtl/mips32_ctrl_decode.sv
// Pure combinational decode of (state, opcode, zero) into the datapath control word.
module mips32_ctrl_decode
    import mips32_pkg::*;
(
    input  state_t     i_state,
    input  logic [5:0] i_opcode,
    input  logic       i_zero,
    output ctrl_t      o_ctrl
);

    always_comb begin
        // NOTE: zero every field before the case so no path leaves a field unassigned (no latch).
        o_ctrl = '0;
        unique case (i_state)
            FETCH: begin
                o_ctrl.mem_read  = 1'b1;
                o_ctrl.ir_write  = 1'b1;
                o_ctrl.alu_src_b = SRCB_FOUR;
                o_ctrl.alu_op    = ALU_ADD;
                o_ctrl.pc_source = PCSRC_ALU;
                o_ctrl.pc_en     = 1'b1;
            end
            DECODE: begin
                o_ctrl.alu_src_b = SRCB_IMM_SH2;
                o_ctrl.alu_op    = ALU_ADD;
                if (!is_legal_op(i_opcode)) begin
                    o_ctrl.illegal_op = 1'b1;
                    o_ctrl.instr_done = 1'b1;
                end
            end
            MEMADR: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_IMM;
                o_ctrl.alu_op    = ALU_ADD;
            end
            MEMRD: begin
                o_ctrl.iord     = 1'b1;
                o_ctrl.mem_read = 1'b1;
            end
            MEMWB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
                o_ctrl.instr_done = 1'b1;
            end
            MEMWR: begin
                o_ctrl.iord       = 1'b1;
                o_ctrl.mem_write  = 1'b1;
                o_ctrl.instr_done = 1'b1;
            end
            RTYPE: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_B;
                o_ctrl.alu_op    = ALU_RTYPE;
            end
            RWB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.reg_dst    = 1'b1;
                o_ctrl.instr_done = 1'b1;
            end
            BRANCH: begin
                // Compare A-B through the ALU; the target was precomputed into ALUOut in DECODE.
                o_ctrl.alu_src_a  = 1'b1;
                o_ctrl.alu_src_b  = SRCB_B;
                o_ctrl.alu_op     = ALU_SUB;
                o_ctrl.pc_source  = PCSRC_ALUOUT;
                o_ctrl.instr_done = 1'b1;
                o_ctrl.pc_en      = (i_opcode == OP_BNE) ? ~i_zero : i_zero;
            end
            JUMP: begin
                o_ctrl.pc_source  = PCSRC_JUMP;
                o_ctrl.pc_en      = 1'b1;
                o_ctrl.instr_done = 1'b1;
            end
            IEXEC: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_IMM;
                case (i_opcode)
                    OP_ANDI: o_ctrl.alu_op = ALU_AND;
                    OP_ORI:  o_ctrl.alu_op = ALU_OR;
                    OP_SLTI: o_ctrl.alu_op = ALU_SLT;
                    default: o_ctrl.alu_op = ALU_ADD;
                endcase
            end
            IWB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.instr_done = 1'b1;
            end
            default: o_ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mips32_multi_cycle_control.sv
// Main multi-cycle MIPS32 control FSM: state register, next-state logic and
// retired-instruction counter; output decode lives in mips32_ctrl_decode.
module mips32_multi_cycle_control
    import mips32_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input logic                          clk,
    input logic                          reset,
    mips32_multi_cycle_control_if.master bus
);

    state_t           r_state;
    state_t           w_next_state;
    ctrl_t            w_ctrl;
    logic             w_instr_done;
    logic [CNT_W-1:0] r_retired;

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) r_state <= FETCH;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = FETCH;
        unique case (r_state)
            FETCH: w_next_state = DECODE;
            DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW:                      w_next_state = MEMADR;
                    OP_RTYPE:                          w_next_state = RTYPE;
                    OP_BEQ, OP_BNE:                    w_next_state = BRANCH;
                    OP_J:                              w_next_state = JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: w_next_state = IEXEC;
                    default:                           w_next_state = FETCH;
                endcase
            end
            MEMADR:  w_next_state = (bus.opcode == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   w_next_state = MEMWB;
            RTYPE:   w_next_state = RWB;
            IEXEC:   w_next_state = IWB;
            default: w_next_state = FETCH;
        endcase
    end

    mips32_ctrl_decode u_decode (
        .i_state  (r_state),
        .i_opcode (bus.opcode),
        .i_zero   (bus.zero),
        .o_ctrl   (w_ctrl)
    );

    // Reset holds FETCH but must not load PC/IR or touch memory while asserted.
    assign w_instr_done   = w_ctrl.instr_done & ~reset;
    assign bus.pc_en      = w_ctrl.pc_en & ~reset;
    assign bus.ir_write   = w_ctrl.ir_write & ~reset;
    assign bus.mem_read   = w_ctrl.mem_read & ~reset;
    assign bus.instr_done = w_instr_done;
    assign bus.iord       = w_ctrl.iord;
    assign bus.mem_write  = w_ctrl.mem_write;
    assign bus.reg_dst    = w_ctrl.reg_dst;
    assign bus.mem_to_reg = w_ctrl.mem_to_reg;
    assign bus.reg_write  = w_ctrl.reg_write;
    assign bus.alu_src_a  = w_ctrl.alu_src_a;
    assign bus.alu_src_b  = w_ctrl.alu_src_b;
    assign bus.alu_op     = w_ctrl.alu_op;
    assign bus.pc_source  = w_ctrl.pc_source;
    assign bus.illegal_op = w_ctrl.illegal_op;
    assign bus.state      = r_state;
    assign bus.retired    = r_retired;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)             r_retired <= '0;
        else if (w_instr_done) r_retired <= r_retired + CNT_W'(1);
    end

endmodule

// File: tb/tb_mips32_multi_cycle_control.sv
// Self-checking bench: per-instruction vector table driven cycle by cycle, with
// expected control words queued by the driver and popped by the sampler.
module tb_mips32_multi_cycle_control;

    localparam int CNT_W = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;

    mips32_multi_cycle_control_if #(.CNT_W(CNT_W)) bus ();

    mips32_multi_cycle_control #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc_en;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_source;
        logic [3:0] state;
        logic       instr_done;
        logic       illegal_op;
    } obs_t;

    typedef struct packed {
        obs_t        ctrl;
        logic [31:0] retired;
    } exp_t;

    typedef struct {
        logic [5:0]  opcode;
        logic        zero;
        int          len;
        logic [19:0] seq;   // state of cycle k in bits [4k+3:4k]
    } vec_t;

    localparam int NVEC = 13;
    vec_t        vecs[NVEC];
    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_retired = 0;

    // Reference control word, written straight from the state/output table.
    function automatic obs_t model(input logic [3:0] st, input logic [5:0] op, input logic z);
        obs_t m;
        m = '0;
        m.state = st;
        case (st)
            4'd0: begin m.mem_read = 1; m.ir_write = 1; m.alu_src_b = 2'b01; m.pc_en = 1; end
            4'd1: begin
                m.alu_src_b = 2'b11;
                if (!(op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
                                 6'b000010, 6'b001000, 6'b001100, 6'b001101, 6'b001010})) begin
                    m.illegal_op = 1; m.instr_done = 1;
                end
            end
            4'd2:  begin m.alu_src_a = 1; m.alu_src_b = 2'b10; end
            4'd3:  begin m.iord = 1; m.mem_read = 1; end
            4'd4:  begin m.reg_write = 1; m.mem_to_reg = 1; m.instr_done = 1; end
            4'd5:  begin m.iord = 1; m.mem_write = 1; m.instr_done = 1; end
            4'd6:  begin m.alu_src_a = 1; m.alu_op = 3'b010; end
            4'd7:  begin m.reg_write = 1; m.reg_dst = 1; m.instr_done = 1; end
            4'd8:  begin
                m.alu_src_a = 1; m.alu_op = 3'b001; m.pc_source = 2'b01; m.instr_done = 1;
                m.pc_en = (op == 6'b000101) ? ~z : z;
            end
            4'd9:  begin m.pc_source = 2'b10; m.pc_en = 1; m.instr_done = 1; end
            4'd10: begin
                m.alu_src_a = 1; m.alu_src_b = 2'b10;
                m.alu_op = (op == 6'b001100) ? 3'b011 :
                           (op == 6'b001101) ? 3'b100 :
                           (op == 6'b001010) ? 3'b101 : 3'b000;
            end
            4'd11: begin m.reg_write = 1; m.instr_done = 1; end
            default: m = '0;
        endcase
        return m;
    endfunction

    function automatic obs_t reset_model();
        obs_t m;
        m = model(4'd0, 6'b000000, 1'b0);
        m.pc_en = 0; m.ir_write = 0; m.mem_read = 0;
        return m;
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o.pc_en = bus.pc_en;         o.iord = bus.iord;
        o.mem_read = bus.mem_read;   o.mem_write = bus.mem_write;
        o.ir_write = bus.ir_write;   o.reg_dst = bus.reg_dst;
        o.mem_to_reg = bus.mem_to_reg; o.reg_write = bus.reg_write;
        o.alu_src_a = bus.alu_src_a; o.alu_src_b = bus.alu_src_b;
        o.alu_op = bus.alu_op;       o.pc_source = bus.pc_source;
        o.state = bus.state;         o.instr_done = bus.instr_done;
        o.illegal_op = bus.illegal_op;
        return o;
    endfunction

    task automatic check(input string what, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", what, act, exp);
        end
    endtask

    task automatic push_exp(input obs_t c);
        exp_t e;
        e.ctrl = c;
        e.retired = exp_retired;
        exp_q.push_back(e);
    endtask

    task automatic sample(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            check({tag, " scoreboard empty"}, 64'd1, 64'd0);
            return;
        end
        e = exp_q.pop_front();
        check({tag, " ctrl"}, 64'(observe()), 64'(e.ctrl));
        check({tag, " retired"}, 64'(bus.retired), 64'(e.retired));
    endtask

    // Called at a negedge with the DUT in FETCH; returns at a negedge in FETCH.
    task automatic run_instr(input int i);
        logic [19:0] seq;
        seq = vecs[i].seq;
        bus.opcode = vecs[i].opcode;
        bus.funct  = 6'($urandom_range(0, 63));
        bus.zero   = vecs[i].zero;
        for (int k = 0; k < vecs[i].len; k++) begin
            push_exp(model(seq[k*4 +: 4], vecs[i].opcode, vecs[i].zero));
            #1;
            sample($sformatf("vec%0d op=%b z=%b cyc%0d", i, vecs[i].opcode, vecs[i].zero, k));
            @(negedge clk);
        end
        exp_retired++;
    endtask

    initial begin
        vecs[0]  = '{6'b100011, 1'b0, 5, {4'd4, 4'd3, 4'd2, 4'd1, 4'd0}};  // lw
        vecs[1]  = '{6'b101011, 1'b1, 4, {4'd0, 4'd5, 4'd2, 4'd1, 4'd0}};  // sw
        vecs[2]  = '{6'b000000, 1'b0, 4, {4'd0, 4'd7, 4'd6, 4'd1, 4'd0}};  // R-type
        vecs[3]  = '{6'b000100, 1'b1, 3, {4'd0, 4'd0, 4'd8, 4'd1, 4'd0}};  // beq taken
        vecs[4]  = '{6'b000100, 1'b0, 3, {4'd0, 4'd0, 4'd8, 4'd1, 4'd0}};  // beq not taken
        vecs[5]  = '{6'b000101, 1'b0, 3, {4'd0, 4'd0, 4'd8, 4'd1, 4'd0}};  // bne taken
        vecs[6]  = '{6'b000101, 1'b1, 3, {4'd0, 4'd0, 4'd8, 4'd1, 4'd0}};  // bne not taken
        vecs[7]  = '{6'b001000, 1'b0, 4, {4'd0, 4'd11, 4'd10, 4'd1, 4'd0}}; // addi
        vecs[8]  = '{6'b001100, 1'b1, 4, {4'd0, 4'd11, 4'd10, 4'd1, 4'd0}}; // andi
        vecs[9]  = '{6'b001101, 1'b0, 4, {4'd0, 4'd11, 4'd10, 4'd1, 4'd0}}; // ori
        vecs[10] = '{6'b001010, 1'b0, 4, {4'd0, 4'd11, 4'd10, 4'd1, 4'd0}}; // slti
        vecs[11] = '{6'b111111, 1'b0, 2, {4'd0, 4'd0, 4'd0, 4'd1, 4'd0}};  // illegal
        vecs[12] = '{6'b000010, 1'b0, 3, {4'd0, 4'd0, 4'd9, 4'd1, 4'd0}};  // j

        bus.opcode = 6'b000000;
        bus.funct  = 6'b000000;
        bus.zero   = 1'b0;

        // Reset state: FETCH decode with PC/IR/memory-read enables forced low.
        repeat (2) @(negedge clk);
        push_exp(reset_model());
        #1 sample("reset");
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < NVEC; i++) run_instr(i);

        // Abort an lw in MEMRD: reset acts immediately and clears the counter.
        bus.opcode = 6'b100011;
        bus.zero   = 1'b0;
        for (int k = 0; k < 4; k++) begin
            push_exp(model(4'(k), 6'b100011, 1'b0));
            #1 sample($sformatf("abort lw cyc%0d", k));
            @(negedge clk);
        end
        // Back at a negedge one cycle on from MEMRD would be MEMWB; rewind by re-entering MEMRD.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_retired = 0;
        for (int k = 0; k < 3; k++) begin
            push_exp(model(4'(k), 6'b100011, 1'b0));
            #1 sample($sformatf("pre-abort lw cyc%0d", k));
            @(negedge clk);
        end
        push_exp(model(4'd3, 6'b100011, 1'b0));
        #1 sample("in MEMRD");
        #1 reset = 1'b1;
        exp_retired = 0;
        push_exp(reset_model());
        #1 sample("async reset in MEMRD");
        @(posedge clk);
        push_exp(reset_model());
        #1 sample("reset held over edge");
        @(negedge clk);
        reset = 1'b0;

        run_instr(0);
        run_instr(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1);
    end

endmodule
